// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and response-slot state encoding for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int WORD = 32;
    localparam int ADDR = 16;
    localparam int LEN  = 1 << ADDR;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        HOLD     = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals around the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    // Requests: req is sampled and granted combinationally in the same cycle.
    // Responses: a beat transfers on a rising edge where rvalid && rready; rvalid
    // and rdata stay stable while rvalid=1 and rready=0.
    logic              i_req;
    logic [ADDR-1:0]   i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [WORD-1:0]   i_rdata;
    logic              i_rready;

    logic              d_req;
    logic              d_we;
    logic [ADDR-1:0]   d_addr;
    logic [WORD-1:0]   d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD-1:0]   d_rdata;
    logic              d_rready;

    logic [ADDR-1:0]   mem_a;
    logic              mem_w;
    logic [WORD-1:0]   mem_d;
    logic [WORD-1:0]   mem_q;

    resp_state_t       i_state;
    resp_state_t       d_state;

    modport slave (
        input  i_req, i_addr, i_rready,
        input  d_req, d_we, d_addr, d_wdata, d_rready,
        input  mem_q,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_a, mem_w, mem_d,
        output i_state, d_state
    );

    modport master (
        output i_req, i_addr, i_rready,
        output d_req, d_we, d_addr, d_wdata, d_rready,
        output mem_q,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_a, mem_w, mem_d,
        input  i_state, d_state
    );

endinterface

// File: rtl/mem_port_arbiter_resp_slot.sv
// Per-port read response tracker: presents mem_q the cycle after a read grant and
// parks it in a hold register if the consumer stalls.
module mem_port_arbiter_resp_slot
    import mem_port_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            grant_read,
    input  logic            rready,
    input  logic [WORD-1:0] mem_q,
    output logic            rvalid,
    output logic [WORD-1:0] rdata,
    output resp_state_t     state
);

    resp_state_t     state_next;
    logic [WORD-1:0] hold_q;
    logic            hold_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hold_q <= '0;
        end else begin
            state <= state_next;
            if (hold_load) begin
                hold_q <= mem_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        hold_load  = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        case (state)
            IDLE: begin
                if (grant_read) begin
                    state_next = INFLIGHT;
                end
            end
            INFLIGHT: begin
                rvalid = 1'b1;
                rdata  = mem_q;
                if (rready) begin
                    state_next = grant_read ? INFLIGHT : IDLE;
                end else begin
                    // mem_q is overwritten by the next access, so capture it now
                    hold_load  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                rvalid = 1'b1;
                rdata  = hold_q;
                if (rready) begin
                    state_next = grant_read ? INFLIGHT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch (I) and
// load/store (D) paths; one access per cycle, read data returned a cycle later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    logic i_elig;
    logic d_elig;
    logic contested;
    logic ptr_d;
    logic i_win;
    logic d_win;

    // A port whose own response is stalled must not issue another access.
    always_comb begin
        i_elig    = bus.i_req && !(bus.i_rvalid && !bus.i_rready);
        d_elig    = bus.d_req && !(bus.d_rvalid && !bus.d_rready);
        contested = i_elig && d_elig;
        i_win     = i_elig && !(d_elig && ptr_d);
        d_win     = d_elig && !(i_elig && !ptr_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_d <= 1'b1;
        end else if (contested) begin
            ptr_d <= !ptr_d;
        end
    end

    always_comb begin
        bus.i_gnt = i_win;
        bus.d_gnt = d_win;
        bus.mem_a = '0;
        bus.mem_w = 1'b0;
        bus.mem_d = '0;
        if (d_win) begin
            bus.mem_a = bus.d_addr;
            bus.mem_w = bus.d_we;
            bus.mem_d = bus.d_wdata;
        end else if (i_win) begin
            bus.mem_a = bus.i_addr;
        end
    end

    mem_port_arbiter_resp_slot u_i_slot (
        .clk        (clk),
        .rst        (rst),
        .grant_read (i_win),
        .rready     (bus.i_rready),
        .mem_q      (bus.mem_q),
        .rvalid     (bus.i_rvalid),
        .rdata      (bus.i_rdata),
        .state      (bus.i_state)
    );

    mem_port_arbiter_resp_slot u_d_slot (
        .clk        (clk),
        .rst        (rst),
        .grant_read (d_win && !bus.d_we),
        .rready     (bus.d_rready),
        .mem_q      (bus.mem_q),
        .rvalid     (bus.d_rvalid),
        .rdata      (bus.d_rdata),
        .state      (bus.d_state)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a transaction-level
// reference model (pending-response queues plus a reference memory).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory device ----------------
    logic [WORD-1:0] mem_arr [logic [ADDR-1:0]];
    logic [WORD-1:0] ref_mem [logic [ADDR-1:0]];

    function automatic logic [WORD-1:0] init_word(input logic [ADDR-1:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [WORD-1:0] dev_rd(input logic [ADDR-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    endfunction

    function automatic logic [WORD-1:0] ref_rd(input logic [ADDR-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        bus.mem_q <= dev_rd(bus.mem_a);
        if (bus.mem_w) mem_arr[bus.mem_a] = bus.mem_d;
    end

    // ---------------- reference model ----------------
    logic [WORD-1:0] exp_i_q [$];
    logic [WORD-1:0] exp_d_q [$];
    logic            m_ptr_d;
    logic            exp_i_gnt, exp_d_gnt, exp_contest;
    logic            exp_mem_w;
    logic [ADDR-1:0] exp_mem_a;
    logic [WORD-1:0] exp_mem_d;
    logic            exp_i_rvalid, exp_d_rvalid;
    logic [WORD-1:0] exp_i_rdata, exp_d_rdata;

    function automatic void model_eval();
        logic i_ok, d_ok;
        exp_i_rvalid = exp_i_q.size() != 0;
        exp_d_rvalid = exp_d_q.size() != 0;
        exp_i_rdata  = exp_i_rvalid ? exp_i_q[0] : '0;
        exp_d_rdata  = exp_d_rvalid ? exp_d_q[0] : '0;
        i_ok = bus.i_req && !(exp_i_rvalid && !bus.i_rready);
        d_ok = bus.d_req && !(exp_d_rvalid && !bus.d_rready);
        exp_contest = i_ok && d_ok;
        if (exp_contest) begin
            exp_d_gnt = m_ptr_d;
            exp_i_gnt = !m_ptr_d;
        end else begin
            exp_d_gnt = d_ok;
            exp_i_gnt = i_ok;
        end
        exp_mem_a = exp_d_gnt ? bus.d_addr : (exp_i_gnt ? bus.i_addr : '0);
        exp_mem_w = exp_d_gnt && bus.d_we;
        exp_mem_d = exp_d_gnt ? bus.d_wdata : '0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_i_q.delete();
            exp_d_q.delete();
            m_ptr_d <= 1'b1;
        end else begin
            if (exp_i_q.size() != 0 && bus.i_rready) void'(exp_i_q.pop_front());
            if (exp_d_q.size() != 0 && bus.d_rready) void'(exp_d_q.pop_front());
            if (exp_i_gnt) exp_i_q.push_back(ref_rd(bus.i_addr));
            if (exp_d_gnt && !bus.d_we) exp_d_q.push_back(ref_rd(bus.d_addr));
            if (exp_d_gnt && bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
            if (exp_contest) m_ptr_d <= !m_ptr_d;
        end
    end

    // Outputs whose value is undefined in the current cycle are masked out.
    function automatic logic [116:0] obs_vec();
        return {bus.i_gnt, bus.d_gnt, bus.mem_w, bus.mem_a,
                exp_i_gnt ? 32'h0 : bus.mem_d,
                bus.i_rvalid, exp_i_rvalid ? bus.i_rdata : 32'h0,
                bus.d_rvalid, exp_d_rvalid ? bus.d_rdata : 32'h0};
    endfunction

    function automatic logic [116:0] exp_vec();
        return {exp_i_gnt, exp_d_gnt, exp_mem_w, exp_mem_a,
                exp_i_gnt ? 32'h0 : exp_mem_d,
                exp_i_rvalid, exp_i_rdata, exp_d_rvalid, exp_d_rdata};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic ir, input logic [ADDR-1:0] ia, input logic irr,
                         input logic dr, input logic dwe, input logic [ADDR-1:0] da,
                         input logic [WORD-1:0] dwd, input logic drr);
        @(negedge clk);
        bus.i_req    = ir;
        bus.i_addr   = ia;
        bus.i_rready = irr;
        bus.d_req    = dr;
        bus.d_we     = dwe;
        bus.d_addr   = da;
        bus.d_wdata  = dwd;
        bus.d_rready = drr;
        #1;
        model_eval();
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_cycle();
        idle_cycle();
        vectors++;
        if ({bus.i_gnt, bus.d_gnt, bus.mem_w, bus.i_rvalid, bus.d_rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.i_gnt, bus.d_gnt, bus.mem_w, bus.i_rvalid, bus.d_rvalid});
        end
        vectors++;
        if ({bus.i_rdata, bus.d_rdata, bus.mem_a} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_data got i=%h d=%h a=%h want all zero",
                     bus.i_rdata, bus.d_rdata, bus.mem_a);
        end
        vectors++;
        if (bus.i_state !== IDLE || bus.d_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state got i=%0d d=%0d want 0", bus.i_state, bus.d_state);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_only_i();
        drive(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        vectors++;
        if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.mem_a !== 16'h0010 || bus.mem_w !== 1'b0) begin
            miscompares++;
            $display("FAIL only_i_grant got gnt=%b%b a=%h w=%b want 10 0010 0",
                     bus.i_gnt, bus.d_gnt, bus.mem_a, bus.mem_w);
        end
        idle_cycle();
        vectors++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL only_i_data got v=%b d=%h want 1 deadbeef", bus.i_rvalid, bus.i_rdata);
        end
        idle_cycle();
        vectors++;
        if (bus.i_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL only_i_drop got v=%b want 0", bus.i_rvalid);
        end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'(k), 1'b1, 1'b1, 1'b0, 16'(16'h0100 + k), 32'(k), 1'b1);
            vectors++;
            if (bus.d_gnt !== (k % 2 == 0) || bus.i_gnt !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL contention_order cyc%0d got i=%b d=%b want d=%b",
                         k, bus.i_gnt, bus.d_gnt, (k % 2 == 0));
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL contention_vec cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_write_read();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 16'h0200, 32'h12345678, 1'b1);
        vectors++;
        if (bus.mem_w !== 1'b1 || bus.mem_a !== 16'h0200 || bus.mem_d !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_grant got w=%b a=%h d=%h want 1 0200 12345678",
                     bus.mem_w, bus.mem_a, bus.mem_d);
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 16'h0200, 32'h0, 1'b1);
        vectors++;
        if (bus.mem_w !== 1'b0 || bus.d_gnt !== 1'b1 || bus.d_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_grant got w=%b gnt=%b rv=%b want 0 1 0", bus.mem_w, bus.d_gnt, bus.d_rvalid);
        end
        idle_cycle();
        vectors++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_rd_data got v=%b d=%h want 1 12345678", bus.d_rvalid, bus.d_rdata);
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        logic [WORD-1:0] want;
        want = init_word(16'h0300);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 16'h0300, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(16'h0040 + k), 1'b1, 1'b1, 1'b0, 16'h0301, 32'h0, 1'b0);
            vectors++;
            if (bus.d_gnt !== 1'b0 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== want) begin
                miscompares++;
                $display("FAIL stall cyc%0d got gnt=%b v=%b d=%h want 0 1 %h",
                         k, bus.d_gnt, bus.d_rvalid, bus.d_rdata, want);
            end
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL stall_vec cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        vectors++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== want) begin
            miscompares++;
            $display("FAIL release got v=%b d=%h want 1 %h", bus.d_rvalid, bus.d_rdata, want);
        end
        idle_cycle();
        vectors++;
        if (bus.d_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL release_drop got v=%b want 0", bus.d_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        idle_cycle();
        vectors++;
        if (bus.i_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre got v=%b want 1", bus.i_rvalid);
        end
        rst = 1'b0;
        #1;
        model_eval();
        vectors++;
        if (bus.i_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b want 0", bus.i_rvalid);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            vectors++;
            if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset cyc%0d got i=%b d=%b want 0 0", k, bus.i_rvalid, bus.d_rvalid);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 16'($urandom_range(0, 31)),
                  $urandom, 1'($urandom_range(0, 3) != 0));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 16'(16'h0060 + k), 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
            vectors++;
            if (bus.i_gnt !== 1'b1 || (k > 0 && bus.i_rdata !== init_word(16'(16'h0060 + k - 1)))) begin
                miscompares++;
                $display("FAIL b2b cyc%0d got gnt=%b d=%h", k, bus.i_gnt, bus.i_rdata);
            end
        end
        idle_cycle();
        idle_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;
        bus.i_rready = 1'b1;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.d_rready = 1'b1;
        test_reset();
        test_only_i();
        test_contention();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port, one-cycle-read-latency 32×64k word memory between the instruction-fetch path and the data load/store path of the processor. It grants at most one access per cycle and drives the memory address, write-enable and write-data lines. Read data is returned to the granted port the following cycle with a valid/ready handshake. A per-port hold register keeps read data stable under back-pressure, because later reads overwrite the memory output register.

## Interface
- WORD, 32, data word width (shared `params.v`)
- ADDR, 16, word address width (shared `params.v`)

- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- i_req  in  1  fetch request (read only)
- i_addr  in  ADDR  fetch word address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  WORD  fetch read data
- i_rready  in  1  fetch consumer accepts i_rdata
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR  data word address
- d_wdata  in  WORD  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  WORD  data read data
- d_rready  in  1  data consumer accepts d_rdata
- mem_a  out  ADDR  memory address
- mem_w  out  1  memory write enable
- mem_d  out  WORD  memory write data
- mem_q  in  WORD  memory registered read output

## Operation
- Per-port response FSM with states IDLE, INFLIGHT and HOLD:
  - IDLE → INFLIGHT when a read is granted.
  - In INFLIGHT: rvalid=1 and rdata=mem_q. If rready=1, go to IDLE, or stay in INFLIGHT if the same port is granted a read again this cycle. If rready=0, capture mem_q into the hold register and go to HOLD.
  - In HOLD: rvalid=1 and rdata=hold. Go to IDLE on rready=1, or to INFLIGHT if regranted in that same cycle.
- Eligibility: a port is eligible when req=1 and it is not (rvalid=1 && rready=0). A port is therefore never granted while its own response is stalled.
- Arbitration:
  - If only one port is eligible, it wins.
  - If both are eligible, the round-robin pointer picks the winner, and the pointer then moves to the other port.
  - The pointer changes only on contested grants. Its reset value favours D.
- Grant is combinational, in the same cycle as req. Winner drives mem_a/mem_w/mem_d: I gives mem_w=0; D gives mem_w=d_we, mem_d=d_wdata.
- D writes complete on grant and produce no response; the D FSM is not changed.
- With no grant: mem_a=0, mem_w=0, mem_d=0. The resulting idle read is harmless, because stalled data is already held.
- The hold registers load only on the INFLIGHT && !rready condition.

## Timing
- Read latency is 1 cycle: a grant at cycle t gives rvalid at t+1 with rdata=mem[addr].
- Back-to-back reads are at full throughput: one grant per cycle, alternating ports under contention.
- A write at t followed by a read of the same address at t+1 returns the new data at t+2.
- Reset values: i/d_rvalid=0, i/d_rdata=0, hold registers 0, FSMs IDLE, pointer=D. Combinational outputs follow inputs, so with req low i/d_gnt=0 and mem_w=0.
- Reset asserted mid-operation discards the in-flight read and any held data. No rvalid is produced after reset deasserts.
- Simultaneous response acceptance and new grant on the same port: the new read's data appears on the next cycle without a bubble.

## Structure
- WORD, ADDR and LEN come from the shared `params.v`. Response FSM state encodings (IDLE=2'd0, INFLIGHT=2'd1, HOLD=2'd2) are added there as localparams.
- One natural sub-module is `resp_slot`: the per-port FSM plus hold register, instantiated twice. Arbitration and the memory mux stay in the top level.
- Target size is about 150–250 lines of RTL.

## Test plan
- **Only I:** i_req at addr 0x0010 with mem[0x10]=0xDEADBEEF → i_gnt at t, i_rvalid and i_rdata=0xDEADBEEF at t+1.
- **Contention after reset:** both request every cycle with rready=1 → grants alternate D,I,D,I; each rvalid follows its grant by one cycle.
- **Write then read:** D writes 0x12345678 to 0x0200, then reads 0x0200 → mem_w=1 on the first grant only; d_rdata=0x12345678 one cycle after the read grant.
- **Back-pressure:** D reads 0x0300, d_rready=0 for 3 cycles while I reads other addresses → d_rdata stays at mem[0x300], d_gnt=0 during the stall; d_rvalid drops the cycle after d_rready=1.
- **Reset mid-read:** rst low in the cycle after an I grant → i_rvalid=0 immediately and stays 0 after release until a new grant.
